// File: rtl/spu_pkg.sv
// spu_pkg
// Shared SPU definitions: retired-packet widths for the even and odd pipes,
// the pipe identifier enum, the queue entry layout and a helper that
// right-aligns an even packet into the odd-width data field.
package spu_pkg;

    localparam int EVEN_PKT_W = 137;
    localparam int ODD_PKT_W  = 169;

    typedef enum logic {
        PIPE_EVEN = 1'b0,
        PIPE_ODD  = 1'b1
    } pipe_e;

    // One queue slot: pipe flag plus a full odd-width data field (170 bits).
    typedef struct packed {
        pipe_e                 pipe;
        logic [ODD_PKT_W-1:0]  data;
    } entry_t;

    // Even packets land in the low-order bits; the top 32 bits read as zero.
    function automatic logic [ODD_PKT_W-1:0] widen_even(input logic [EVEN_PKT_W-1:0] p);
        return {{(ODD_PKT_W-EVEN_PKT_W){1'b0}}, p};
    endfunction

endpackage

// File: rtl/packet_retire_queue.sv
// packet_retire_queue
// Circular FIFO merging retired even-pipe and odd-pipe test packets into a
// single in-order stream. Up to two packets are accepted per cycle (even
// first, then odd); packets that do not fit are dropped and counted in a
// saturating drop counter. The head is presented combinationally from
// storage with a valid/ready handshake.
//
// Ports
//   clk          single clock, all state updates on posedge
//   reset        synchronous, active-high
//   even_valid   even_packet carries a retired even-pipe result
//   even_packet  even-pipe packet [0:136]
//   odd_valid    odd_packet carries a retired odd-pipe result
//   odd_packet   odd-pipe packet [0:168]
//   out_valid    queue head is presented
//   out_ready    consumer accepts the head
//   out_pipe     pipe of the head (0 = even, 1 = odd)
//   out_data     head packet; even packets occupy [32:168], [0:31] = 0
//   occupancy    current entry count
//   drop_count   packets lost to overflow (saturating)
module packet_retire_queue
    import spu_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    even_valid,
    input  logic [0:EVEN_PKT_W-1]   even_packet,
    input  logic                    odd_valid,
    input  logic [0:ODD_PKT_W-1]    odd_packet,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_pipe,
    output logic [0:ODD_PKT_W-1]    out_data,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [0:DROP_W-1]       drop_count
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = DEPTH[PTR_W:0];
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    entry_t              r_mem [DEPTH];
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W:0]      r_occ;
    logic [DROP_W-1:0]   r_drop;

    logic [PTR_W:0]      w_free;
    logic                w_enq_even;
    logic                w_enq_odd;
    logic [1:0]          w_n_enq;
    logic [1:0]          w_n_drop;
    logic                w_deq;
    logic                w_wr0_en;
    logic                w_wr1_en;
    entry_t              w_even_ent;
    entry_t              w_odd_ent;
    entry_t              w_slot0;
    entry_t              w_head;
    logic [DROP_W:0]     w_drop_sum;

    // Free space is judged on start-of-cycle occupancy, so a dequeue in the
    // same cycle never makes room for an incoming packet.
    assign w_free     = DEPTH_C - r_occ;
    assign w_enq_even = even_valid && (w_free != '0);
    // Odd needs a second slot when even is also being written this cycle.
    assign w_enq_odd  = odd_valid && (even_valid ? (w_free >= 2) : (w_free != '0));
    assign w_n_enq    = {1'b0, w_enq_even} + {1'b0, w_enq_odd};
    assign w_n_drop   = {1'b0, even_valid && !w_enq_even} + {1'b0, odd_valid && !w_enq_odd};
    assign w_deq      = out_valid && out_ready;

    assign w_even_ent = '{pipe: PIPE_EVEN, data: widen_even(even_packet)};
    assign w_odd_ent  = '{pipe: PIPE_ODD,  data: odd_packet};

    // Slot at the write pointer takes even when present, else a lone odd;
    // the following slot is only used when both pipes are enqueued.
    assign w_slot0    = w_enq_even ? w_even_ent : w_odd_ent;
    assign w_wr0_en   = w_enq_even || w_enq_odd;
    assign w_wr1_en   = w_enq_even && w_enq_odd;

    assign w_drop_sum = {1'b0, r_drop} + (DROP_W+1)'(w_n_drop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
            r_drop   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_enq);
            if (w_deq)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_occ    <= r_occ + (PTR_W+1)'(w_n_enq) - (PTR_W+1)'(w_deq);
            r_drop   <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
        end
    end

    // Storage is not cleared on reset; emptiness is tracked by r_occ alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_wr0_en)
                r_mem[r_wr_ptr] <= w_slot0;
            if (w_wr1_en)
                r_mem[r_wr_ptr + PTR_ONE] <= w_odd_ent;
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign out_valid  = (r_occ != '0);
    assign out_pipe   = out_valid && (w_head.pipe == PIPE_ODD);
    assign out_data   = out_valid ? w_head.data : '0;
    assign occupancy  = r_occ;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_packet_retire_queue.sv
// tb_packet_retire_queue
// Randomized and directed stimulus against a queue-based reference model of
// the retire queue (entry list, free-space rule, saturating drop total).
module tb_packet_retire_queue;

    localparam int DEPTH  = 8;
    localparam int DROP_W = 5;
    localparam int DMAX   = (1 << DROP_W) - 1;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           even_valid = 1'b0;
    logic [0:136]   even_packet = '0;
    logic           odd_valid = 1'b0;
    logic [0:168]   odd_packet = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           out_pipe;
    logic [0:168]   out_data;
    logic [3:0]     occupancy;
    logic [0:DROP_W-1] drop_count;

    packet_retire_queue #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .even_valid (even_valid),
        .even_packet(even_packet),
        .odd_valid  (odd_valid),
        .odd_packet (odd_packet),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pipe   (out_pipe),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         pipe;
        logic [168:0] data;
    } ment_t;

    ment_t          mq[$];
    int             mdrop = 0;
    logic [168:0]   sb[$];
    bit             sb_on = 1'b0;
    int             n_chk = 0;
    int             n_err = 0;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [168:0] rnd169();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[168:0];
    endfunction

    function automatic logic [136:0] rnd137();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[136:0];
    endfunction

    task automatic check_outputs();
        bit ev;
        ev = (mq.size() != 0);
        chk("valid", out_valid, ev);
        chk("pipe",  out_pipe,  ev ? mq[0].pipe : 1'b0);
        chk("data",  out_data,  ev ? mq[0].data : 169'h0);
        chk("occ",   occupancy, mq.size());
        chk("drop",  drop_count, mdrop);
    endtask

    // Drive one cycle of inputs (called at negedge), advance the model across
    // the next posedge, then compare at the following negedge.
    task automatic cycle(input logic ev, input logic [136:0] ep, input logic ov,
                         input logic [168:0] op, input logic rdy, input logic rst);
        int     free;
        int     nd;
        bit     deq;
        ment_t  e;
        even_valid  = ev;
        even_packet = ep;
        odd_valid   = ov;
        odd_packet  = op;
        out_ready   = rdy;
        reset       = rst;
        if (sb_on && !rst && out_valid && rdy) begin
            if (sb.size() != 0) chk("order", out_data, sb.pop_front());
            else chk("dup", out_valid, 1'b0);
        end
        if (rst) begin
            mq.delete();
            mdrop = 0;
        end else begin
            deq  = (mq.size() != 0) && rdy;
            free = DEPTH - mq.size();
            nd   = 0;
            if (ev) begin
                if (free > 0) begin
                    e.pipe = 1'b0; e.data = {32'h0, ep};
                    mq.push_back(e); free--;
                    if (sb_on) sb.push_back(e.data);
                end else nd++;
            end
            if (ov) begin
                if (free > 0) begin
                    e.pipe = 1'b1; e.data = op;
                    mq.push_back(e); free--;
                    if (sb_on) sb.push_back(e.data);
                end else nd++;
            end
            if (deq) void'(mq.pop_front());
            mdrop = (mdrop + nd > DMAX) ? DMAX : mdrop + nd;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, rnd137(), 1'b0, rnd169(), rdy, 1'b0);
    endtask

    logic [136:0] pa;
    logic [168:0] pb;

    initial begin
        @(negedge clk);
        // Reset with junk on the inputs
        cycle(1'b1, rnd137(), 1'b1, rnd169(), 1'b1, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_occ", occupancy, 0);

        // Single even packet 137'h1
        cycle(1'b1, 137'h1, 1'b0, rnd169(), 1'b1, 1'b0);
        chk("r32_data", out_data, 169'h1);
        chk("r32_pipe", out_pipe, 1'b0);
        idle(1'b1);
        chk("r32_empty", occupancy, 0);

        // Dual write, A then B
        pa = rnd137(); pb = rnd169();
        cycle(1'b1, pa, 1'b1, pb, 1'b1, 1'b0);
        chk("r33_a", out_data, {32'h0, pa});
        idle(1'b1);
        chk("r33_b", out_data, pb);
        chk("r33_pipe", out_pipe, 1'b1);
        idle(1'b1);

        // Fill with dual writes, then overflow by two
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, rnd137(), 1'b1, rnd169(), 1'b0, 1'b0);
        chk("r34_full", occupancy, 8);
        chk("r34_nodrop", drop_count, 0);
        cycle(1'b1, rnd137(), 1'b1, rnd169(), 1'b0, 1'b0);
        chk("r34_occ", occupancy, 8);
        chk("r34_drop", drop_count, 2);

        // Occupancy 7, dual write with dequeue: even in, odd dropped
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, rnd137(), 1'b1, rnd169(), 1'b0, 1'b0);
        cycle(1'b1, rnd137(), 1'b0, rnd169(), 1'b0, 1'b0);
        chk("r35_pre", occupancy, 7);
        cycle(1'b1, rnd137(), 1'b1, rnd169(), 1'b1, 1'b0);
        chk("r35_occ", occupancy, 7);
        chk("r35_drop", drop_count, 1);

        // Reset mid-operation at occupancy 5 with valids high
        idle(1'b1);
        idle(1'b1);
        chk("r37_pre", occupancy, 5);
        cycle(1'b1, rnd137(), 1'b1, rnd169(), 1'b1, 1'b1);
        chk("r37_occ", occupancy, 0);
        chk("r37_valid", out_valid, 1'b0);
        chk("r37_drop", drop_count, 0);

        // Stream 20 packets with random ready; no loss allowed, order kept
        sb_on = 1'b1;
        begin
            int sent;
            int budget;
            logic ev, ov;
            sent = 0;
            budget = 0;
            while (sent < 20 && budget < 400) begin
                budget++;
                ev = ($urandom_range(0, 1) == 1) && (DEPTH - mq.size() >= 2);
                ov = ($urandom_range(0, 1) == 1) && (DEPTH - mq.size() >= 2) && (sent + ev < 20);
                sent += int'(ev) + int'(ov);
                cycle(ev, rnd137(), ov, rnd169(), $urandom_range(0, 2) != 0, 1'b0);
            end
            chk("r36_sent", sent, 20);
            budget = 0;
            while (out_valid && budget < 100) begin
                budget++;
                cycle(1'b0, rnd137(), 1'b0, rnd169(), $urandom_range(0, 1) == 1, 1'b0);
            end
            chk("r36_drain", occupancy, 0);
            chk("r36_sb", sb.size(), 0);
            chk("r36_drop", drop_count, 0);
        end
        sb_on = 1'b0;

        // Free-running random traffic with occasional resets; low ready phases
        // push the drop counter into saturation.
        for (int i = 0; i < 400; i++) begin
            logic rdy;
            rdy = (i % 100 < 50) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            cycle($urandom_range(0, 2) != 0, rnd137(), $urandom_range(0, 2) != 0, rnd169(),
                  rdy, $urandom_range(0, 149) == 0);
        end

        // Saturation: hold ready low until full, then keep dropping
        for (int i = 0; i < 30; i++) cycle(1'b1, rnd137(), 1'b1, rnd169(), 1'b0, 1'b0);
        chk("sat_drop", drop_count, DMAX);
        chk("sat_occ", occupancy, DEPTH);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
